serial_paralelo: RTL
====================

# serial_paralelo

Receive-side serial-to-parallel converter for the PCIe PHY lane. It sits directly downstream of `paralelo_serial` and consumes its 1-bit, MSB-first stream on `clk_32f`. It hunts for the COM symbol (8'hBC) at any bit phase and declares the lane active after four consecutive aligned COMs. Once active, it delivers each non-COM byte as a parallel word with a valid flag and a one-cycle byte strobe.

## Interface
- `COM`, 8'hBC: idle/comma symbol used for alignment.
- `LOCK_COUNT`, 4: consecutive aligned COMs required to enter ALIGNED.
- `clk_32f`  in  1  bit clock; sole clock, all logic on rising edge.
- `reset_L`  in  1  synchronous, active-low reset.
- `data_in`  in  1  serial bit, MSB of each byte first.
- `data_out`  out  8  last received non-COM byte.
- `valid_out`  out  1  1 when the byte presented at `byte_en` is data, not COM.
- `byte_en`  out  1  one-cycle pulse per aligned byte while active.
- `active`  out  1  lane aligned and locked.

## Operation
- Shift register: `sr <= {sr[6:0], data_in}` every cycle, including in all states.
- Phase counter `bit_cnt` runs 0..7 and wraps. A boundary cycle is the cycle where `bit_cnt` wraps to 0; on that cycle the updated `sr` holds one complete aligned byte.
- FSM states: HUNT, SYNC, ALIGNED.
  - HUNT: every cycle, compare the updated `sr` with COM. On a match, set `bit_cnt=0`, `com_cnt=1`, go to SYNC. `active=0`.
  - SYNC: at each boundary, if the byte is COM, increment `com_cnt`. When `com_cnt` reaches `LOCK_COUNT`, go to ALIGNED. If the byte is not COM, go to HUNT and set `com_cnt=0`. No outputs change.
  - ALIGNED: `active=1`. At each boundary, pulse `byte_en`.
    - Non-COM byte: `data_out<=byte`, `valid_out=1`.
    - COM byte: `data_out` holds, `valid_out=0`.
  - ALIGNED is left only by reset, or by realignment when `SP_REALIGN_EN` is defined.
- `com_cnt` is 3 bits and saturates; it never wraps.

## Timing
- Reset (`reset_L=0` at a rising edge): `data_out=8'h00`, `valid_out=0`, `byte_en=0`, `active=0`, `sr=0`, `bit_cnt=0`, state HUNT. All outputs are registered.
- Reset mid-operation: the next edge clears everything. Four fresh aligned COMs are required to lock again.
- Output latency: `data_out`, `valid_out` and `byte_en` update on the edge following the boundary cycle. This is one cycle after the byte's last bit is sampled.
- `active` rises on the same edge as the first ALIGNED-state output update, i.e. one cycle after the 4th COM boundary.
- `byte_en` is high for exactly 1 of every 8 cycles while active; otherwise it is 0.
- `valid_out` holds its value until the next `byte_en`. `valid_out=0` while inactive.
- Minimum lock time from reset release: 32 bits of COM plus 1 cycle.

## Configuration
- `SP_REALIGN_EN` defined:
  - While ALIGNED, COM is also checked at non-boundary phases.
  - If COM appears at the same non-boundary offset in 4 consecutive byte periods, the FSM goes to HUNT. On that edge `active=0`, `valid_out=0` and `byte_en=0`.
  - The misaligned counter clears in any byte period without a match at that offset, or when the offset changes.
- `SP_REALIGN_EN` undefined: no misaligned-COM logic. ALIGNED is exited only by reset.

## Test plan
- Hold `reset_L=0` for 10 cycles with `data_in` toggling -> all outputs 0 and `active=0` throughout.
- Send 4×8'hBC then 8'h55, 8'hA3, MSB first, from phase 0 -> `active` rises 1 cycle after the 4th COM boundary. `byte_en` then pulses with `data_out=8'h55`, `valid_out=1`, then 8 cycles later with 8'hA3.
- Send 3 junk bits (1,0,1) before 4×BC, then 8'h0F -> lock at the shifted phase and `data_out=8'h0F`, proving arbitrary-phase acquisition.
- Send 3×BC then 8'h00 then 8'h11 -> `active` stays 0, no `byte_en`, FSM back in HUNT.
- Once locked with last byte 8'hA3, send BC -> `byte_en` pulse, `valid_out=0`, `data_out` stays 8'hA3.
- Assert `reset_L=0` for 1 cycle mid-byte while locked -> all outputs 0 next edge. With `SP_REALIGN_EN` defined, 4 COMs shifted by 3 bits while locked -> `active` drops to 0.

Source files
------------

// File: rtl/serial_paralelo.sv
// serial_paralelo: receive-side serial-to-parallel converter for one PCIe PHY lane.
// Hunts for COM (8'hBC) at any bit phase, locks after LOCK_COUNT aligned COMs,
// then presents each aligned byte with a one-cycle byte_en strobe.
// Optional feature macro: SP_REALIGN_EN (drops lock when COM keeps showing up
// at the same non-boundary offset while aligned).
module serial_paralelo (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_en,
    output logic       active
);

    localparam logic [7:0]  COM        = 8'hBC;
    localparam int unsigned LOCK_COUNT = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        SYNC    = 2'd1,
        ALIGNED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    com_cnt_q, com_cnt_d;
    logic                pend_q, pend_d;
    logic [BYTE_W-1:0]   data_out_q, data_out_d;
    logic                valid_out_q, valid_out_d;
    logic                byte_en_q, byte_en_d;
    logic                active_q, active_d;

    logic                boundary_c;
    logic                com_hit_c;
    logic                realign_c;

    // Shift in the new bit and flag boundary / COM on the updated window
    always_comb begin
        sr_d       = {sr_q[BYTE_W-2:0], data_in};
        boundary_c = (bit_cnt_q == CNT_W'(BYTE_W - 1));
        com_hit_c  = (sr_d == COM);
    end

`ifdef SP_REALIGN_EN
    logic [CNT_W-1:0] mis_off_q, mis_off_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             mis_seen_q, mis_seen_d;

    // Track COM hits at a fixed non-boundary offset across byte periods
    always_comb begin
        mis_off_d  = mis_off_q;
        mis_cnt_d  = mis_cnt_q;
        mis_seen_d = mis_seen_q;
        realign_c  = 1'b0;
        if (state_q != ALIGNED) begin
            mis_off_d  = '0;
            mis_cnt_d  = '0;
            mis_seen_d = 1'b0;
        end else if (boundary_c) begin
            // A byte period with no hit at the tracked offset breaks the run
            if (!mis_seen_q) begin
                mis_cnt_d = '0;
            end
            mis_seen_d = 1'b0;
        end else if (com_hit_c) begin
            mis_seen_d = 1'b1;
            if ((mis_cnt_q != '0) && (bit_cnt_q == mis_off_q)) begin
                mis_cnt_d = mis_cnt_q + CNT_W'(1);
            end else begin
                mis_off_d = bit_cnt_q;
                mis_cnt_d = CNT_W'(1);
            end
            realign_c = (mis_cnt_d >= CNT_W'(LOCK_COUNT));
        end
    end

    // Misaligned-COM tracking registers
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            mis_off_q  <= '0;
            mis_cnt_q  <= '0;
            mis_seen_q <= 1'b0;
        end else begin
            mis_off_q  <= mis_off_d;
            mis_cnt_q  <= mis_cnt_d;
            mis_seen_q <= mis_seen_d;
        end
    end
`else
    assign realign_c = 1'b0;
`endif

    // Alignment FSM next-state and registered output values
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        com_cnt_d   = com_cnt_q;
        pend_d      = 1'b0;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        byte_en_d   = 1'b0;
        active_d    = 1'b0;

        unique case (state_q)
            HUNT: begin
                com_cnt_d   = '0;
                valid_out_d = 1'b0;
                if (com_hit_c) begin
                    bit_cnt_d = '0;
                    com_cnt_d = CNT_W'(1);
                    state_d   = SYNC;
                end
            end
            SYNC: begin
                valid_out_d = 1'b0;
                if (boundary_c) begin
                    if (com_hit_c) begin
                        if (com_cnt_q != '1) begin
                            com_cnt_d = com_cnt_q + CNT_W'(1);
                        end
                        if (com_cnt_d >= CNT_W'(LOCK_COUNT)) begin
                            state_d = ALIGNED;
                        end
                    end else begin
                        com_cnt_d = '0;
                        state_d   = HUNT;
                    end
                end
            end
            ALIGNED: begin
                active_d = 1'b1;
                // Byte completed at the previous edge is now in sr_q
                pend_d   = boundary_c;
                if (pend_q) begin
                    byte_en_d = 1'b1;
                    if (sr_q != COM) begin
                        data_out_d  = sr_q;
                        valid_out_d = 1'b1;
                    end else begin
                        valid_out_d = 1'b0;
                    end
                end
                if (realign_c) begin
                    state_d     = HUNT;
                    com_cnt_d   = '0;
                    pend_d      = 1'b0;
                    byte_en_d   = 1'b0;
                    valid_out_d = 1'b0;
                    active_d    = 1'b0;
                end
            end
            default: begin
                state_d   = HUNT;
                com_cnt_d = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            com_cnt_q   <= '0;
            pend_q      <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            byte_en_q   <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            com_cnt_q   <= com_cnt_d;
            pend_q      <= pend_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            byte_en_q   <= byte_en_d;
            active_q    <= active_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign byte_en   = byte_en_q;
    assign active    = active_q;

endmodule
